// File: rtl/life_pkg.sv
// Shared definitions for the 16x16 Game of Life blocks: board geometry,
// sequencer state encoding and the row/column to board-bit mapping.
package life_pkg;

    localparam int unsigned BOARD_DIM  = 16;
    localparam int unsigned BOARD_BITS = 256;
    localparam int unsigned LOAD_BYTES = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned GEN_W      = 16;
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned CELL_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EVAL    = 2'd2,
        ST_CAPTURE = 2'd3
    } seq_state_t;

    // Bit index of cell (row, col): row*16 + col, i.e. row in the upper nibble.
    function automatic logic [CELL_W-1:0] cell_index(input logic [COORD_W-1:0] row,
                                                     input logic [COORD_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/life_sequencer_if.sv
// Seed byte stream plus the board/select/result path to the next-state block.
// The master modport is the sequencer's view of these signals.
interface life_sequencer_if;
    import life_pkg::*;

    logic                  load_valid;
    logic [BYTE_W-1:0]     load_data;
    logic                  load_ready;
    logic [BOARD_BITS-1:0] board_input;
    logic                  select;
    logic [BOARD_BITS-1:0] board_output;

    modport master (
        input  load_valid,
        input  load_data,
        input  board_output,
        output load_ready,
        output board_input,
        output select
    );

    modport slave (
        output load_valid,
        output load_data,
        output board_output,
        input  load_ready,
        input  board_input,
        input  select
    );

endinterface

// File: rtl/life_tick_timer.sv
// Generation pacing counter: done is asserted once the counter has seen
// max(period,1) enabled cycles; a period change applies on the next compare.
module life_tick_timer #(
    parameter int unsigned TICK_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [TICK_W-1:0] period,
    output logic              done
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;
    logic [TICK_W:0]   limit;

    // Compare one bit wider so the current cycle can be counted without overflow.
    always_comb begin
        limit = (period == '0) ? (TICK_W+1)'(1) : {1'b0, period};
        done  = (({1'b0, cnt_q} + (TICK_W+1)'(1)) >= limit);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Upstream control for the Game of Life next-state block: owns the board,
// loads seeds from a byte stream, paces generations and reports status.
module life_sequencer
    import life_pkg::*;
#(
    parameter int unsigned TICK_W = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    life_sequencer_if.master       bus,
    input  logic                   run,
    input  logic                   step,
    input  logic                   clear,
    input  logic [TICK_W-1:0]      tick_period,
    output logic [GEN_W-1:0]       gen_count,
    output logic                   stable,
    output logic                   extinct,
    output logic                   busy
);

    seq_state_t            state_q, state_d;
    logic [BOARD_BITS-1:0] board_q, board_d;
    logic [GEN_W-1:0]      gen_q, gen_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  stable_q, stable_d;
    logic                  select_q;
    logic                  busy_q;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_done;
    logic                  new_stable;

    life_tick_timer #(
        .TICK_W (TICK_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .period (tick_period),
        .done   (tmr_done)
    );

    // Next-state, load path and status update.
    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        gen_d      = gen_q;
        idx_d      = idx_q;
        stable_d   = stable_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        new_stable = (bus.board_output == board_q);

        if (clear) begin
            state_d  = ST_IDLE;
            board_d  = '0;
            gen_d    = '0;
            idx_d    = '0;
            stable_d = 1'b0;
            tmr_clr  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.load_valid) begin
                        board_d[{idx_q, 3'b000} +: BYTE_W] = bus.load_data;
                        idx_d    = idx_q + IDX_W'(1);
                        gen_d    = '0;
                        stable_d = 1'b0;
                    end else if (step) begin
                        state_d = ST_EVAL;
                    end else if (run && !stable_q) begin
                        state_d = ST_RUN;
                        tmr_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                        tmr_clr = 1'b1;
                    end else if (tmr_done) begin
                        state_d = ST_EVAL;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_EVAL: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    board_d  = bus.board_output;
                    stable_d = new_stable;
                    if (gen_q != '1) begin
                        gen_d = gen_q + GEN_W'(1);
                    end
                    if (run && !new_stable) begin
                        state_d = ST_RUN;
                        tmr_clr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // select and busy are registered from the next state so they align with EVAL/busy states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            board_q  <= '0;
            gen_q    <= '0;
            idx_q    <= '0;
            stable_q <= 1'b0;
            select_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            gen_q    <= gen_d;
            idx_q    <= idx_d;
            stable_q <= stable_d;
            select_q <= (state_d == ST_EVAL);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign bus.board_input = board_q;
    assign bus.select      = select_q;
    assign bus.load_ready  = (state_q == ST_IDLE);
    assign gen_count       = gen_q;
    assign stable          = stable_q;
    assign busy            = busy_q;
    assign extinct         = (board_q == '0);

endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer; the bench also plays the role of
// the registered next-state block (non-wrapping 16x16 Life rule).
module tb_life_sequencer;
    import life_pkg::*;

    localparam int unsigned TW = 24;
    localparam logic [255:0] BLINK_H = 256'b111 << 17;
    localparam logic [255:0] BLINK_V = (256'b1 << 2) | (256'b1 << 18) | (256'b1 << 34);
    localparam logic [255:0] BLOCK   = (256'b11) | (256'b11 << 16);
    localparam logic [255:0] CELL0   = 256'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          step;
    logic          clear;
    logic [TW-1:0] tick_period;
    logic [15:0]   gen_count;
    logic          stable;
    logic          extinct;
    logic          busy;

    life_sequencer_if lif();

    life_sequencer #(.TICK_W(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (lif),
        .run         (run),
        .step        (step),
        .clear       (clear),
        .tick_period (tick_period),
        .gen_count   (gen_count),
        .stable      (stable),
        .extinct     (extinct),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [255:0] seed;
        logic [255:0] exp_board;
        int           exp_stable;
        int           exp_extinct;
    } vec_t;

    vec_t         vecs[5];
    vec_t         exp_q[$];
    vec_t         cur;
    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    int           cyc      = 0;
    int           sel_cnt  = 0;
    int           sel_t[$];
    logic [255:0] sel_b[$];

    function automatic logic [255:0] life_next(input logic [255:0] b);
        logic [255:0] nb;
        int n, rr, cc;
        nb = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16)
                            if (b[rr*16+cc]) n++;
                    end
                end
                nb[r*16+c] = (n == 3) || (b[r*16+c] && n == 2);
            end
        end
        return nb;
    endfunction

    // Next-state block model: registers its result on the closing edge of EVAL.
    always @(posedge clk or posedge reset) begin
        if (reset) lif.board_output <= '0;
        else if (lif.select) lif.board_output <= life_next(lif.board_input);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lif.select === 1'b1) begin
            sel_cnt++;
            sel_t.push_back(cyc);
            sel_b.push_back(lif.board_input);
        end
    end

    task automatic check_i(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic check_b(input string nm, input logic [255:0] act, input logic [255:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_reset(input string nm);
        check_b({nm, "_board"}, lif.board_input, '0);
        check_i({nm, "_select"}, int'(lif.select), 0);
        check_i({nm, "_ready"}, int'(lif.load_ready), 1);
        check_i({nm, "_gen"}, int'(gen_count), 0);
        check_i({nm, "_stable"}, int'(stable), 0);
        check_i({nm, "_extinct"}, int'(extinct), 1);
        check_i({nm, "_busy"}, int'(busy), 0);
    endtask

    task automatic load_board(input logic [255:0] b);
        for (int k = 0; k < 32; k++) begin
            lif.load_valid = 1'b1;
            lif.load_data  = b[8*k +: 8];
            @(negedge clk);
        end
        lif.load_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_i({nm, "_idle"}, int'(busy), 0);
    endtask

    task automatic check_spacing(input string nm, input int gap, input int min_pulses);
        check_i({nm, "_enough_pulses"}, int'(sel_t.size() >= min_pulses), 1);
        for (int i = 1; i < sel_t.size(); i++) begin
            check_i({nm, "_gap"}, sel_t[i] - sel_t[i-1], gap);
            check_b({nm, "_phase"}, sel_b[i], (sel_b[i-1] == BLINK_H) ? BLINK_V : BLINK_H);
        end
    endtask

    initial begin
        int s0;
        logic [255:0] exp33;

        vecs[0] = '{"blinker_h", BLINK_H, BLINK_V, 0, 0};
        vecs[1] = '{"block",     BLOCK,   BLOCK,   1, 0};
        vecs[2] = '{"cell0",     CELL0,   '0,      0, 1};
        vecs[3] = '{"empty",     '0,      '0,      1, 1};
        vecs[4] = '{"blinker_v", BLINK_V, BLINK_H, 0, 0};

        reset = 1'b1; run = 1'b0; step = 1'b0; clear = 1'b0; tick_period = TW'(1);
        lif.load_valid = 1'b0; lif.load_data = '0;
        repeat (2) @(negedge clk);
        check_reset("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset("post_rst");

        // Single-step each seed and check step latency plus committed status.
        foreach (vecs[i]) begin
            load_board(vecs[i].seed);
            check_i({vecs[i].name, "_gen_after_load"}, int'(gen_count), 0);
            check_i({vecs[i].name, "_stable_after_load"}, int'(stable), 0);
            check_b({vecs[i].name, "_loaded"}, lif.board_input, vecs[i].seed);
            exp_q.push_back(vecs[i]);
            s0 = sel_cnt;
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            check_i({vecs[i].name, "_sel_e0"}, int'(lif.select), 1);
            check_i({vecs[i].name, "_busy_e0"}, int'(busy), 1);
            @(negedge clk);
            check_i({vecs[i].name, "_sel_e1"}, int'(lif.select), 0);
            check_i({vecs[i].name, "_busy_e1"}, int'(busy), 1);
            check_b({vecs[i].name, "_hold_e1"}, lif.board_input, vecs[i].seed);
            @(negedge clk);
            check_i({vecs[i].name, "_busy_e2"}, int'(busy), 0);
            cur = exp_q.pop_front();
            check_b({cur.name, "_board"}, lif.board_input, cur.exp_board);
            check_i({cur.name, "_gen"}, int'(gen_count), 1);
            check_i({cur.name, "_stable"}, int'(stable), cur.exp_stable);
            check_i({cur.name, "_extinct"}, int'(extinct), cur.exp_extinct);
            check_i({cur.name, "_one_select"}, sel_cnt - s0, 1);
        end

        // Block in free-run: one generation, then still-life halt.
        load_board(BLOCK);
        tick_period = TW'(4);
        s0 = sel_cnt;
        run = 1'b1;
        repeat (120) @(negedge clk);
        check_i("block_run_selects", sel_cnt - s0, 1);
        check_i("block_run_stable", int'(stable), 1);
        check_i("block_run_gen", int'(gen_count), 1);
        check_i("block_run_busy", int'(busy), 0);
        check_b("block_run_board", lif.board_input, BLOCK);
        run = 1'b0;

        // Blinker free-run at period 10, then period 0.
        load_board(BLINK_H);
        tick_period = TW'(10);
        sel_t.delete();
        sel_b.delete();
        run = 1'b1;
        repeat (60) @(negedge clk);
        run = 1'b0;
        wait_idle("blink10", 30);
        check_b("blink10_first", sel_b.size() > 0 ? sel_b[0] : '0, BLINK_H);
        check_spacing("blink10", 12, 4);

        tick_period = '0;
        sel_t.delete();
        sel_b.delete();
        run = 1'b1;
        repeat (20) @(negedge clk);
        run = 1'b0;
        wait_idle("blink0", 30);
        check_spacing("blink0", 3, 5);

        // Clear while EVAL: result must be dropped.
        pulse_clear();
        load_board(BLINK_H);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check_i("clr_eval_in_eval", int'(lif.select), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_b("clr_eval_board", lif.board_input, '0);
        check_i("clr_eval_gen", int'(gen_count), 0);
        check_i("clr_eval_ready", int'(lif.load_ready), 1);
        check_i("clr_eval_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check_b("clr_eval_no_capture", lif.board_input, '0);
        check_i("clr_eval_gen_later", int'(gen_count), 0);

        // Asynchronous reset in the middle of RUN.
        load_board(BLINK_H);
        tick_period = TW'(10);
        run = 1'b1;
        repeat (5) @(negedge clk);
        check_i("mid_run_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_reset("rst_run");
        @(negedge clk);
        reset = 1'b0;
        run = 1'b0;
        @(negedge clk);

        // 33 bytes: index wraps, byte 32 overwrites bits [7:0].
        exp33 = '0;
        for (int k = 0; k < 33; k++) begin
            lif.load_valid = 1'b1;
            lif.load_data  = (k == 32) ? 8'hAA : 8'(k + 1);
            if (k < 32) exp33[8*k +: 8] = 8'(k + 1);
            @(negedge clk);
        end
        lif.load_valid = 1'b0;
        exp33[7:0] = 8'hAA;
        check_b("load33_board", lif.board_input, exp33);

        // Load attempt while RUN is refused.
        pulse_clear();
        load_board(BLINK_H);
        tick_period = TW'(10);
        run = 1'b1;
        repeat (3) @(negedge clk);
        check_i("run_load_ready", int'(lif.load_ready), 0);
        lif.load_valid = 1'b1;
        lif.load_data  = 8'hFF;
        repeat (2) @(negedge clk);
        lif.load_valid = 1'b0;
        check_b("run_load_nowrite", lif.board_input, BLINK_H);
        run = 1'b0;
        wait_idle("run_load", 30);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
